// File: rtl/lsu_mem_master_if.sv
// rtl/lsu_mem_master_if.sv - core request/response and data memory port bundle
//
// Groups every handshake and bus signal of lsu_mem_master.
//   modport master : the LSU view (accepts requests, returns responses, drives the memory port)
//   modport slave  : the environment view (core MEM stage plus data memory)
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : byte-addressed request
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                     : single response per request
//   m_addr/m_wr_dat/rd_en/wr_en/m_rd_dat                      : word-addressed memory port
interface lsu_mem_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] m_addr;
   logic [31:0] m_wr_dat;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] m_rd_dat;

   modport master (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, m_rd_dat,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, m_addr, m_wr_dat, rd_en, wr_en
   );

   modport slave (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, m_rd_dat,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, m_addr, m_wr_dat, rd_en, wr_en
   );
endinterface

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store initiator for a word-addressed data memory
//
// Accepts one byte-addressed load/store at a time, converts it to a word access,
// performs read-modify-write for SB/SH (the memory has no byte enables), extends
// load data and returns one response with an error flag.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : lsu_mem_master_if.master (request, response and memory port)
// Parameters:
//   ADDR_W : word-index bits, memory holds 2**ADDR_W words
//   RD_LAT : memory read latency; only 1 is implemented
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned LH/LHU/SH/LW/SW fault;
//                          when undefined, the offending low address bits are ignored.
module lsu_mem_master #(
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 1
) (
   input logic              clk,
   input logic              reset,
   lsu_mem_master_if.master bus
);

   typedef enum logic [2:0] {IDLE, RD, RD_CAP, WR, RESP} state_t;

   state_t      state, state_nxt;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [1:0]  lane_q;
   logic [15:0] wdata_q;

   logic        f3_illegal, range_err, misalign_err, fault, accept;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data, merge_data;

   // RD_CAP samples m_rd_dat exactly one cycle after RD; longer latencies are not built.
   if (RD_LAT != 1) begin : g_rd_lat_unsupported
   end

   always_comb begin
      if (bus.req_we) f3_illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
      else            f3_illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
   end

   assign range_err = |bus.req_addr[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign_err = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                         ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
   assign misalign_err = 1'b0;
`endif

   assign fault  = f3_illegal | range_err | misalign_err;
   assign accept = (state == IDLE) && bus.req_valid;

   // Lane selection; halfword uses only addr[1], so a masked misaligned access lands on its halfword.
   always_comb begin
      byte_sel = bus.m_rd_dat[8*lane_q +: 8];
      half_sel = lane_q[1] ? bus.m_rd_dat[31:16] : bus.m_rd_dat[15:0];
      case (funct3_q[1:0])
         2'b00:   load_data = {{24{~funct3_q[2] & byte_sel[7]}}, byte_sel};
         2'b01:   load_data = {{16{~funct3_q[2] & half_sel[15]}}, half_sel};
         default: load_data = bus.m_rd_dat;
      endcase
      merge_data = bus.m_rd_dat;
      if (funct3_q[1:0] == 2'b00) merge_data[8*lane_q +: 8]      = wdata_q[7:0];
      else                        merge_data[16*lane_q[1] +: 16] = wdata_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.req_valid) begin
            if (fault)                              state_nxt = RESP;
            else if (!bus.req_we)                   state_nxt = RD;
            else if (bus.req_funct3[1:0] == 2'b10)  state_nxt = WR;
            else                                    state_nxt = RD;
         end
         RD:      state_nxt = RD_CAP;
         RD_CAP:  state_nxt = we_q ? WR : RESP;
         WR:      state_nxt = RESP;
         RESP:    if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes decode straight from the state register, so each lasts exactly one state.
   always_comb begin
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rd_en     = 1'b0;
      bus.wr_en     = 1'b0;
      case (state)
         IDLE:    bus.req_ready = reset;
         RD:      bus.rd_en     = 1'b1;
         WR:      bus.wr_en     = 1'b1;
         RESP:    bus.rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q          <= 1'b0;
         funct3_q      <= 3'b000;
         lane_q        <= 2'b00;
         wdata_q       <= 16'h0;
         bus.m_addr    <= 32'h0;
         bus.m_wr_dat  <= 32'h0;
         bus.rsp_rdata <= 32'h0;
         bus.rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               we_q          <= bus.req_we;
               funct3_q      <= bus.req_funct3;
               lane_q        <= bus.req_addr[1:0];
               wdata_q       <= bus.req_wdata[15:0];
               bus.m_addr    <= {{(32-ADDR_W){1'b0}}, bus.req_addr[ADDR_W+1:2]};
               bus.rsp_rdata <= 32'h0;
               bus.rsp_err   <= fault;
               if (!fault && bus.req_we && (bus.req_funct3[1:0] == 2'b10))
                  bus.m_wr_dat <= bus.req_wdata;
            end
            RD_CAP: begin
               if (we_q) bus.m_wr_dat  <= merge_data;
               else      bus.rsp_rdata <= load_data;
            end
            RESP: if (bus.rsp_ready) bus.rsp_err <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - randomized self-checking bench for lsu_mem_master
module tb_lsu_mem_master;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   lsu_mem_master_if bus();

   lsu_mem_master #(.ADDR_W(10), .RD_LAT(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
   endfunction

   // Data memory: one-cycle read latency, writes land on the strobe edge.
   logic [31:0] mem [1024];
   bit          written [1024];
   always @(posedge clk) begin
      if (bus.wr_en) begin
         mem[bus.m_addr[9:0]]     <= bus.m_wr_dat;
         written[bus.m_addr[9:0]] <= 1'b1;
      end
      if (bus.rd_en)
         bus.m_rd_dat <= written[bus.m_addr[9:0]] ? mem[bus.m_addr[9:0]] : init_word(int'(bus.m_addr[9:0]));
   end

   logic [31:0] ref_mem [1024];
   logic [31:0] last_rdata, last_wr_dat, last_wr_addr;
   logic        last_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference model: expected outcome computed from the byte-level rules.
   task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output bit err, output logic [31:0] rdata,
                        output int lat, output int n_rd, output int n_wr,
                        output logic [31:0] wdat, output int idx);
      bit legal, mis;
      int size, off;
      logic [31:0] mask, v;
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      size  = 1 << f3[1:0];
      mis   = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
      err   = !legal || (addr >= 32'h1000) || (TRAP && mis);
      idx   = int'(addr[11:2]);
      off   = (size == 4) ? 0 : (size == 2) ? int'(addr & 32'd2) : int'(addr & 32'd3);
      mask  = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8*size)) - 32'd1;
      rdata = 32'h0;
      wdat  = 32'h0;
      n_rd  = 0;
      n_wr  = 0;
      if (err) begin
         lat = 1;
      end else if (!we) begin
         v = (ref_mem[idx] >> (8*off)) & mask;
         if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
         rdata = v;
         lat   = 3;
         n_rd  = 1;
      end else begin
         wdat = (ref_mem[idx] & ~(mask << (8*off))) | ((wdata & mask) << (8*off));
         ref_mem[idx] = wdat;
         lat  = (size == 4) ? 2 : 4;
         n_rd = (size == 4) ? 0 : 1;
         n_wr = 1;
      end
   endtask

   // hold < 0: rsp_ready raised before the request (early); otherwise held low for hold cycles.
   task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold);
      bit e_err; logic [31:0] e_rdata, e_wdat; int e_lat, e_rd, e_wr, e_idx;
      int lat, n_rd, n_wr, budget;
      bit overlap;
      logic [31:0] rd_addr, wr_addr, wr_dat, held;
      model(we, f3, addr, wdata, e_err, e_rdata, e_lat, e_rd, e_wr, e_wdat, e_idx);
      budget = 0;
      while (!bus.req_ready && budget < 20) begin tick(); budget++; end
      check("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
      bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
      bus.req_valid = 1'b1;
      bus.rsp_ready = (hold < 0);
      tick();
      bus.req_valid = 1'b0;
      lat = 1; n_rd = 0; n_wr = 0; overlap = 0;
      rd_addr = 32'hX; wr_addr = 32'hX; wr_dat = 32'hX;
      while (!bus.rsp_valid && lat < 20) begin
         if (bus.rd_en) begin n_rd++; rd_addr = bus.m_addr; end
         if (bus.wr_en) begin n_wr++; wr_addr = bus.m_addr; wr_dat = bus.m_wr_dat; end
         if (bus.rd_en && bus.wr_en) overlap = 1;
         tick();
         lat++;
      end
      check("rsp_valid_seen", {31'b0, bus.rsp_valid}, 32'd1);
      check("latency", 32'(lat), 32'(e_lat));
      check("rd_strobes", 32'(n_rd), 32'(e_rd));
      check("wr_strobes", 32'(n_wr), 32'(e_wr));
      check("strobe_overlap", {31'b0, overlap}, 32'd0);
      check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e_err});
      check("rsp_rdata", bus.rsp_rdata, e_rdata);
      if (e_rd > 0) check("rd_addr", rd_addr, 32'(e_idx));
      if (e_wr > 0) begin
         check("wr_addr", wr_addr, 32'(e_idx));
         check("wr_data", wr_dat, e_wdat);
      end
      last_rdata = bus.rsp_rdata; last_err = bus.rsp_err;
      last_wr_dat = wr_dat; last_wr_addr = wr_addr;
      held = bus.rsp_rdata;
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
         check("hold_rdata", bus.rsp_rdata, held);
         check("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      check("post_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("post_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
      check("post_req_ready", {31'b0, bus.req_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      bit we; logic [2:0] f3; logic [31:0] addr; int wr_seen;
      logic [2:0] ld_ops [5];
      ld_ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0;
      bus.req_wdata = 0; bus.rsp_ready = 0;

      tick(); tick();
      check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
      check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("rst_strobes", {30'b0, bus.rd_en, bus.wr_en}, 32'd0);
      check("rst_m_addr", bus.m_addr, 32'd0);
      check("rst_m_wr_dat", bus.m_wr_dat, 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
      reset = 1'b1;
      tick();
      check("idle_req_ready", {31'b0, bus.req_ready}, 32'd1);

      do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
      check("sw_wr_dat", last_wr_dat, 32'hDEADBEEF);
      check("sw_wr_addr", last_wr_addr, 32'd4);
      do_req(0, 3'b000, 32'h13, 32'h0, -1);
      check("lb_const", last_rdata, 32'hFFFFFFDE);
      do_req(0, 3'b100, 32'h13, 32'h0, 1);
      check("lbu_const", last_rdata, 32'h000000DE);
      do_req(0, 3'b001, 32'h10, 32'h0, 0);
      check("lh_const", last_rdata, 32'hFFFFBEEF);
      do_req(0, 3'b101, 32'h10, 32'h0, 0);
      check("lhu_const", last_rdata, 32'h0000BEEF);
      do_req(1, 3'b000, 32'h11, 32'h55, 0);
      check("sb_const", last_wr_dat, 32'hDEAD55EF);
      do_req(0, 3'b010, 32'h1002, 32'h0, 0);
      check("range_err_const", {31'b0, last_err}, 32'd1);
      do_req(0, 3'b010, 32'hFFC, 32'h0, 0);
      check("top_word_const", last_rdata, init_word(1023));
      do_req(0, 3'b010, 32'h12, 32'h0, 0);
      if (TRAP) check("misalign_err_const", {31'b0, last_err}, 32'd1);
      else      check("misalign_mask_const", last_rdata, 32'hDEAD55EF);
      do_req(0, 3'b010, 32'h10, 32'h0, 5);

      // Reset while in RD_CAP of an SB: no write may follow.
      bus.req_we = 1; bus.req_funct3 = 3'b000; bus.req_addr = 32'h20; bus.req_wdata = 32'hAA;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      tick();
      #2 reset = 1'b0;
      #1;
      check("midrst_strobes", {30'b0, bus.rd_en, bus.wr_en}, 32'd0);
      check("midrst_m_addr", bus.m_addr, 32'd0);
      check("midrst_m_wr_dat", bus.m_wr_dat, 32'd0);
      check("midrst_req_ready", {31'b0, bus.req_ready}, 32'd0);
      wr_seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.wr_en) wr_seen++;
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.wr_en) wr_seen++;
      end
      check("midrst_no_wr", 32'(wr_seen), 32'd0);
      check("midrst_req_ready_back", {31'b0, bus.req_ready}, 32'd1);
      do_req(0, 3'b010, 32'h20, 32'h0, 0);

      for (int n = 0; n < 150; n++) begin
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
         else if (we)                   f3 = 3'($urandom_range(0, 2));
         else                           f3 = ld_ops[$urandom_range(0, 4)];
         case ($urandom_range(0, 7))
            0:       addr = 32'h1000 + ($urandom & 32'hFFF);
            1:       addr = $urandom;
            2:       addr = 32'hFFC | 32'($urandom_range(0, 3));
            3:       addr = 32'($urandom_range(0, 4095));
            default: addr = 32'($urandom_range(0, 63));
         endcase
         do_req(we, f3, addr, $urandom, $urandom_range(0, 4) - 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-addressed data memory port (m_addr, m_wr_dat, rd_en, wr_en, m_rd_dat) on behalf of the RISC-V core's MEM stage.
- Accepts one byte-addressed request at a time over a valid/ready handshake.
- Converts byte addresses to word indices and performs read-modify-write for SB/SH, because the memory has no byte enables.
- Sign- or zero-extends load data and returns a single response with an error flag.

Parameters:
- ADDR_W, 10, number of word-index bits; the memory holds 2**ADDR_W 32-bit words.
- RD_LAT, 1, memory read latency in cycles: m_rd_dat is valid RD_LAT cycles after the cycle in which rd_en is high. Only 1 is required.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; low forces the reset state immediately.
- req_valid  in  1  core request valid.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU for loads; 000 SB, 001 SH, 010 SW for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response valid; held until accepted.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and on error.
- rsp_err  out  1  misaligned, range or illegal-funct3 fault.
- m_addr  out  32  word index = zero-extended req_addr[ADDR_W+1:2].
- m_wr_dat  out  32  write word to memory.
- rd_en  out  1  memory read strobe.
- wr_en  out  1  memory write strobe.
- m_rd_dat  in  32  memory read data.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; req_ready=0 while reset is low, then 1 in IDLE; rsp_valid, rsp_err, rd_en, wr_en=0; rsp_rdata, m_addr, m_wr_dat=0; all latched request fields=0.
- Reset mid-operation abandons the transaction with no further memory strobes. A write strobe already sampled by the memory is not undone.
- All memory-side outputs are registered (Moore). rd_en and wr_en are each high for exactly one cycle per access and are never high together.
- States: IDLE, RD, RD_CAP, WR, RESP.
- IDLE: on req_valid & req_ready, latch we, funct3, addr and wdata, then check faults:
  - illegal funct3: load funct3 not in {000, 001, 010, 100, 101}, or store funct3 not in {000, 001, 010};
  - range: req_addr[31:ADDR_W+2] != 0;
  - misaligned: see Optional Feature.
- Any fault -> RESP with rsp_err=1 and no memory access.
- Otherwise:
  - load -> RD;
  - SW -> WR with m_wr_dat=wdata;
  - SB/SH -> RD (read-modify-write).
- RD: rd_en=1, m_addr=word index. Next state RD_CAP.
- RD_CAP: sample m_rd_dat.
  - Load: select the byte lane (addr[1:0]) or halfword lane (addr[1]); sign-extend for LB/LH, zero-extend for LBU/LHU; pass LW unchanged. Result goes to rsp_rdata; next state RESP.
  - SB/SH: merge wdata[7:0] or wdata[15:0] into the selected lane of m_rd_dat, other bytes unchanged; result goes to m_wr_dat; next state WR.
- WR: wr_en=1 for one cycle; next state RESP.
- RESP: rsp_valid=1; rsp_rdata and rsp_err held stable. On rsp_ready, go to IDLE and clear rsp_valid and rsp_err.
  - rsp_ready is only sampled in RESP; asserting it early has no effect.
  - A new request is not accepted in the cycle the response is consumed; req_ready rises the following cycle.
- Latency from the accept edge to rsp_valid:
  - load: 3 cycles;
  - SW: 2 cycles;
  - SB/SH: 4 cycles;
  - fault: 1 cycle.
- Wrap-around: the highest word index, 2**ADDR_W-1, is legal. The next word up is a range fault.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, produce rsp_err=1 and no memory access.
- Undefined: these low address bits are silently masked (LH/LHU/SH use addr[1]; LW/SW use lane 0) and the access proceeds normally with rsp_err=0.

Test Plan:
- Reset released, then SW addr=0x10 wdata=0xDEADBEEF -> single wr_en cycle with m_addr=4 and m_wr_dat=0xDEADBEEF; rsp_valid 2 cycles after accept with rsp_err=0.
- Memory word 4 holds 0xDEADBEEF; LB addr=0x13 -> rsp_rdata=0xFFFFFFDE. LBU addr=0x13 -> 0x000000DE. LH addr=0x10 -> 0xFFFFBEEF. LHU -> 0x0000BEEF.
- SB addr=0x11 wdata=0x55 onto 0xDEADBEEF -> rd_en, then wr_en with m_wr_dat=0xDEAD55EF; rsp_valid 4 cycles after accept.
- LW addr=0x1002 with ADDR_W=10 -> rsp_err=1 (range fault); rd_en and wr_en never asserted; LW addr=0xFFC reads word 1023.
- LW addr=0x12: with LSU_MISALIGN_TRAP_EN -> rsp_err=1 and no strobe; without it -> reads word 4 with rsp_err=0.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0. Separately, assert reset=0 during RD_CAP -> outputs zero immediately and no wr_en follows.
